wb_regfile: RTL and testbench

Writeback stage and integer register file of the RV32I pipeline. It consumes the fields registered by the MEM/WB pipeline register and selects the writeback value: ALU result, or a sign/zero-extended load lane. It commits that value into a 32×32 register file with x0 hardwired to zero, and serves the decode stage's two read ports with same-cycle write bypass. It also exports the writeback bus for EX-stage forwarding and, optionally, a retired-instruction counter.

---
 rtl/wb_regfile.sv | 207 ++++++++++++++++++++
 tb/tb_wb_regfile.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and 32x32 integer register file of the RV32I core.
//
// The block selects the writeback value, which is either the ALU result or an
// extended load lane. It commits that value to the register file and serves
// two combinational read ports, which see a write in the same cycle through a
// bypass. The writeback bus is exported for EX-stage forwarding.
//
// Optional feature macro: RETIRE_CNT_EN
//   defined   -> INSTRET_W-bit retired-instruction counter and instret_o port
//   undefined -> no counter, no instret_o port
module wb_regfile #(
    parameter int INSTRET_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] load_out_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic        wb_en_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o
`ifdef RETIRE_CNT_EN
    ,
    output logic [INSTRET_W-1:0] instret_o
`endif
);

    // ------------------------------------------------------------------
    // Opcode encodings
    // ------------------------------------------------------------------
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    // Bubbles injected by the pipeline carry an all-zero opcode.
    localparam logic [6:0] OPC_NOP    = 7'b0000000;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // A counter narrower than one bit cannot be built.
    if (INSTRET_W < 1) begin : g_bad_instret_w
        $error("wb_regfile: INSTRET_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // True for every opcode that produces a register result.
    function automatic logic is_writing(input logic [6:0] opc);
        logic w;
        w = 1'b0;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: w = 1'b1;
            default:                     w = 1'b0;
        endcase
        return w;
    endfunction

    // Byte lane selected by the low address bits.
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [1:0]  off);
        logic [7:0] b;
        b = word[7:0];
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // Half lane selected by address bit 1. Address bit 0 is ignored because
    // misaligned halves are not split across lanes.
    function automatic logic [15:0] half_lane(input logic [31:0] word,
                                              input logic        hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

    // Extends the selected lane to 32 bits according to funct3.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic        [31:0] res;
        sb  = byte_lane(word, off);
        sh  = half_lane(word, off[1]);
        res = word;
        case (f3)
            F3_LB:   res = {{24{sb[7]}}, sb};
            F3_LBU:  res = {24'd0, sb};
            F3_LH:   res = {{16{sh[15]}}, sh};
            F3_LHU:  res = {16'd0, sh};
            F3_LW:   res = word;
            default: res = word;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Writeback value selection
    // ------------------------------------------------------------------
    logic        is_load;
    logic [31:0] load_val;

    assign is_load  = (opcode_i == OPC_LOAD);
    assign load_val = load_extend(funct3_i, alu_out_i[1:0], load_out_i);

    // The writeback bus is gated only by the enable. The data tracks the
    // inputs even during reset so that forwarding logic sees a stable value.
    assign wb_en_o   = is_writing(opcode_i) && (rd_i != 5'd0) && !rst;
    assign wb_rd_o   = rd_i;
    assign wb_data_o = is_load ? load_val : alu_out_i;

    // ------------------------------------------------------------------
    // Register array, x1..x31. x0 has no storage.
    // ------------------------------------------------------------------
    logic [31:0] regs [1:31];

    // Commit the writeback value, or clear every register on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_en_o) begin
            regs[rd_i] <= wb_data_o;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with same-cycle bypass
    // ------------------------------------------------------------------

    // Resolves one read port. x0 wins over the bypass, and the bypass wins
    // over stored contents. wb_en_o is already low during reset, so the
    // bypass is suppressed there without any further gating.
    function automatic logic [31:0] read_port(input logic [4:0]  addr,
                                              input logic        byp_en,
                                              input logic [4:0]  byp_rd,
                                              input logic [31:0] byp_data,
                                              input logic [31:0] stored);
        logic [31:0] d;
        if (addr == 5'd0) begin
            d = 32'd0;
        end else if (byp_en && (addr == byp_rd)) begin
            d = byp_data;
        end else begin
            d = stored;
        end
        return d;
    endfunction

    logic [31:0] rs1_stored;
    logic [31:0] rs2_stored;

    // Array lookups for both ports. Address 0 is masked later in read_port.
    always_comb begin
        rs1_stored = 32'd0;
        rs2_stored = 32'd0;
        if (rs1_addr_i != 5'd0) begin
            rs1_stored = regs[rs1_addr_i];
        end
        if (rs2_addr_i != 5'd0) begin
            rs2_stored = regs[rs2_addr_i];
        end
    end

    assign rs1_data_o = read_port(rs1_addr_i, wb_en_o, rd_i, wb_data_o, rs1_stored);
    assign rs2_data_o = read_port(rs2_addr_i, wb_en_o, rd_i, wb_data_o, rs2_stored);

`ifdef RETIRE_CNT_EN
    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
    logic [INSTRET_W-1:0] instret_q;

    // Count every non-bubble instruction. This includes stores, branches
    // and writes to x0. The counter wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (opcode_i != OPC_NOP) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// When RETIRE_CNT_EN is defined, a second instance with a 4-bit counter
// covers counter wrap.
module tb_wb_regfile;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_UNDEF  = 7'b1111111;
    localparam logic [6:0] OPC_NOP    = 7'b0000000;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] load_out;
    logic [4:0]  rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef RETIRE_CNT_EN
    logic [63:0] instret;
    logic [31:0] rs1_data4;
    logic [31:0] rs2_data4;
    logic        wb_en4;
    logic [4:0]  wb_rd4;
    logic [31:0] wb_data4;
    logic [3:0]  instret4;
`endif

    int n_checks;
    int n_pass;
    logic [63:0] exp_cnt;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .alu_out_i  (alu_out),
        .load_out_i (load_out),
        .rd_i       (rd),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .wb_en_o    (wb_en),
        .wb_rd_o    (wb_rd),
        .wb_data_o  (wb_data)
`ifdef RETIRE_CNT_EN
        ,
        .instret_o  (instret)
`endif
    );

`ifdef RETIRE_CNT_EN
    wb_regfile #(.INSTRET_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .alu_out_i  (alu_out),
        .load_out_i (load_out),
        .rd_i       (rd),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_data_o (rs1_data4),
        .rs2_data_o (rs2_data4),
        .wb_en_o    (wb_en4),
        .wb_rd_o    (wb_rd4),
        .wb_data_o  (wb_data4),
        .instret_o  (instret4)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and keep the expected retire count in step.
    task automatic tick();
        if (rst) exp_cnt = 64'd0;
        else if (opcode != OPC_NOP) exp_cnt = exp_cnt + 64'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rdi,
                         input logic [31:0] alu, input logic [31:0] ld);
        opcode   = opc;
        funct3   = f3;
        rd       = rdi;
        alu_out  = alu;
        load_out = ld;
        #1;
    endtask

    task automatic read2(input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_cnt  = 64'd0;
        rst = 1'b1;
        opcode = OPC_NOP; funct3 = 3'd0; alu_out = 32'd0; load_out = 32'd0;
        rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        tick();
        tick();

        // While in reset, a writing opcode does not enable writeback.
        drive(OPC_OP, 3'd0, 5'd3, 32'h0000_0033, 32'd0);
        check("wb_en_in_rst", {63'd0, wb_en}, 64'd0);
        check("wb_rd_in_rst", {59'd0, wb_rd}, 64'd3);
        check("wb_data_in_rst", {32'd0, wb_data}, 64'h33);
        drive(OPC_NOP, 3'd0, 5'd0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        #1;
`ifdef RETIRE_CNT_EN
        check("instret_reset", instret, 64'd0);
`endif

        // All 32 addresses read 0 on both ports after reset.
        for (int i = 0; i < 32; i++) begin
            read2(5'(i), 5'(31 - i));
            check("rs1_after_reset", {32'd0, rs1_data}, 64'd0);
            check("rs2_after_reset", {32'd0, rs2_data}, 64'd0);
        end

        // A write to x0 is suppressed.
        drive(OPC_OP, 3'd0, 5'd0, 32'hDEAD_BEEF, 32'd0);
        read2(5'd0, 5'd0);
        check("x0_wb_en", {63'd0, wb_en}, 64'd0);
        check("x0_rs1_same", {32'd0, rs1_data}, 64'd0);
        tick();
        drive(OPC_NOP, 3'd0, 5'd0, 32'd0, 32'd0);
        check("x0_rs1_after", {32'd0, rs1_data}, 64'd0);

        // OP-IMM to x5 with a double bypass.
        drive(OPC_OP_IMM, 3'd0, 5'd5, 32'h1234_5678, 32'd0);
        read2(5'd5, 5'd5);
        check("byp_wb_en", {63'd0, wb_en}, 64'd1);
        check("byp_wb_rd", {59'd0, wb_rd}, 64'd5);
        check("byp_rs1", {32'd0, rs1_data}, 64'h1234_5678);
        check("byp_rs2", {32'd0, rs2_data}, 64'h1234_5678);
        tick();
        drive(OPC_NOP, 3'd0, 5'd5, 32'd0, 32'd0);
        check("nop_wb_en", {63'd0, wb_en}, 64'd0);
        check("x5_stored", {32'd0, rs1_data}, 64'h1234_5678);

        // Load lane extraction, using load word 0x80FF7F01.
        drive(OPC_LOAD, 3'b000, 5'd6, 32'h0000_1003, 32'h80FF_7F01);
        check("lb_off3", {32'd0, wb_data}, 64'hFFFF_FF80);
        drive(OPC_LOAD, 3'b100, 5'd6, 32'h0000_1003, 32'h80FF_7F01);
        check("lbu_off3", {32'd0, wb_data}, 64'h0000_0080);
        drive(OPC_LOAD, 3'b000, 5'd6, 32'h0000_1000, 32'h80FF_7F01);
        check("lb_off0", {32'd0, wb_data}, 64'h0000_0001);
        drive(OPC_LOAD, 3'b000, 5'd6, 32'h0000_1001, 32'h80FF_7F01);
        check("lb_off1", {32'd0, wb_data}, 64'h0000_007F);
        drive(OPC_LOAD, 3'b000, 5'd6, 32'h0000_1002, 32'h80FF_7F01);
        check("lb_off2", {32'd0, wb_data}, 64'hFFFF_FFFF);
        drive(OPC_LOAD, 3'b001, 5'd6, 32'h0000_1002, 32'h80FF_7F01);
        check("lh_off2", {32'd0, wb_data}, 64'hFFFF_80FF);
        drive(OPC_LOAD, 3'b101, 5'd6, 32'h0000_1003, 32'h80FF_7F01);
        check("lhu_off3", {32'd0, wb_data}, 64'h0000_80FF);
        drive(OPC_LOAD, 3'b001, 5'd6, 32'h0000_1001, 32'h80FF_7F01);
        check("lh_off1", {32'd0, wb_data}, 64'h0000_7F01);
        drive(OPC_LOAD, 3'b011, 5'd6, 32'h0000_1003, 32'h80FF_7F01);
        check("ld_f3_011", {32'd0, wb_data}, 64'h80FF_7F01);
        drive(OPC_LOAD, 3'b010, 5'd6, 32'h0000_1001, 32'h80FF_7F01);
        check("lw_off1", {32'd0, wb_data}, 64'h80FF_7F01);
        tick();
        drive(OPC_NOP, 3'd0, 5'd0, 32'd0, 32'd0);
        read2(5'd6, 5'd5);
        check("x6_stored", {32'd0, rs1_data}, 64'h80FF_7F01);

        // STORE and BRANCH do not write x7 but do retire.
`ifdef RETIRE_CNT_EN
        check("instret_pre_sb", instret, exp_cnt);
`endif
        drive(OPC_STORE, 3'b010, 5'd7, 32'h0000_0055, 32'd0);
        check("store_wb_en", {63'd0, wb_en}, 64'd0);
        tick();
        drive(OPC_BRANCH, 3'b000, 5'd7, 32'h0000_0055, 32'd0);
        check("branch_wb_en", {63'd0, wb_en}, 64'd0);
        tick();
        drive(OPC_NOP, 3'd0, 5'd0, 32'd0, 32'd0);
        read2(5'd7, 5'd0);
        check("x7_unchanged", {32'd0, rs1_data}, 64'd0);
`ifdef RETIRE_CNT_EN
        check("instret_post_sb", instret, exp_cnt);
`endif

        // Undefined opcode does not write, and one port bypasses.
        drive(OPC_UNDEF, 3'd0, 5'd9, 32'h0000_0099, 32'd0);
        read2(5'd9, 5'd5);
        check("undef_wb_en", {63'd0, wb_en}, 64'd0);
        check("undef_no_byp", {32'd0, rs1_data}, 64'd0);
        tick();
        drive(OPC_OP, 3'd0, 5'd8, 32'h0000_A5A5, 32'd0);
        read2(5'd8, 5'd5);
        check("mix_rs1_byp", {32'd0, rs1_data}, 64'h0000_A5A5);
        check("mix_rs2_reg", {32'd0, rs2_data}, 64'h1234_5678);
        tick();

        // Stream x1..x4 with reset in the third slot.
        drive(OPC_OP, 3'd0, 5'd1, 32'h0000_0011, 32'd0);
        tick();
        drive(OPC_OP, 3'd0, 5'd2, 32'h0000_0022, 32'd0);
        tick();
        rst = 1'b1;
        drive(OPC_OP, 3'd0, 5'd3, 32'h0000_0033, 32'd0);
        read2(5'd3, 5'd1);
        check("rst_wb_en", {63'd0, wb_en}, 64'd0);
        check("rst_no_byp", {32'd0, rs1_data}, 64'd0);
        check("rst_x1_pre", {32'd0, rs2_data}, 64'h11);
        tick();
        rst = 1'b0;
        drive(OPC_OP, 3'd0, 5'd4, 32'h0000_0044, 32'd0);
        tick();
        drive(OPC_NOP, 3'd0, 5'd0, 32'd0, 32'd0);
        read2(5'd1, 5'd2);
        check("stream_x1", {32'd0, rs1_data}, 64'd0);
        check("stream_x2", {32'd0, rs2_data}, 64'd0);
        read2(5'd3, 5'd4);
        check("stream_x3", {32'd0, rs1_data}, 64'd0);
        check("stream_x4", {32'd0, rs2_data}, 64'h44);
        read2(5'd5, 5'd8);
        check("rst_x5", {32'd0, rs1_data}, 64'd0);
        check("rst_x8", {32'd0, rs2_data}, 64'd0);
`ifdef RETIRE_CNT_EN
        check("instret_stream", instret, 64'd1);
        check("instret_model", instret, exp_cnt);

        // 17 valid instructions after reset wrap the 4-bit counter to 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("instret4_reset", {60'd0, instret4}, 64'd0);
        for (int i = 0; i < 17; i++) begin
            drive(OPC_OP, 3'd0, 5'd10, 32'(i), 32'd0);
            tick();
        end
        drive(OPC_NOP, 3'd0, 5'd0, 32'd0, 32'd0);
        check("instret4_wrap", {60'd0, instret4}, 64'd1);
        check("instret64_17", instret, 64'd17);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
